mdu: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS execute stage. It sits beside `alu` and takes the same forwarded `srca_i`/`srcb_i` operands. It runs `mult`, `multu`, `div`, `divu` iteratively over 32 cycles, implements `mthi`/`mtlo` in one cycle, and holds the architectural HI/LO registers that `mfhi`/`mflo` read. The `busy` output feeds the hazard unit, which stalls the pipeline while an operation is in flight.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_div_step.sv | 19 +
 rtl/mdu.sv | 138 +++++++++++++
 tb/tb_mdu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared opcode encodings and operand helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] md_mult  = 3'd0;
    localparam logic [2:0] md_multu = 3'd1;
    localparam logic [2:0] md_div   = 3'd2;
    localparam logic [2:0] md_divu  = 3'd3;
    localparam logic [2:0] md_mthi  = 3'd4;
    localparam logic [2:0] md_mtlo  = 3'd5;

    localparam int md_iter = 32;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == md_mult) || (op == md_div);
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v,
                                        input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module mdu_div_step (
    input  logic [31:0] rem,
    input  logic        bit_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted  = {rem, bit_in};
    assign diff     = shifted - {1'b0, divisor};
    // No borrow means the shifted remainder covers the divisor.
    assign q_bit    = ~diff[32];
    assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/mdu.sv
// Iterative 32-cycle multiply/divide unit holding the HI/LO registers.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  mdop_i,
    input  logic [31:0] srca_i,
    input  logic [31:0] srcb_i,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  op_q;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_res;
    logic        neg_rem;
    logic [63:0] acc;
    logic [4:0]  cnt;

    logic        accept_iter;
    logic        accept_mv;
    logic        sgn;
    logic        is_div;
    logic [32:0] add_sum;
    logic [63:0] mul_next;
    logic [31:0] rem_next;
    logic        q_bit;
    logic [63:0] div_next;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy        = (state != IDLE);
    assign accept_iter = (state == IDLE) && start_i && !mdop_i[2];
    assign accept_mv   = (state == IDLE) && start_i
                         && (mdop_i == md_mthi || mdop_i == md_mtlo);
    assign sgn         = is_signed_op(mdop_i);
    assign is_div      = op_q[1];

    // Right-shifting product: add multiplicand, then shift one bit out low.
    assign add_sum  = {1'b0, acc[63:32]}
                      + (b_mag[cnt] ? {1'b0, a_mag} : 33'd0);
    assign mul_next = {add_sum, acc[31:1]};

    mdu_div_step u_div_step (
        .rem      (acc[63:32]),
        .bit_in   (a_mag[~cnt]),
        .divisor  (b_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign div_next = {rem_next, acc[30:0], q_bit};
    assign prod     = neg_res ? (~acc + 64'd1) : acc;

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            if (b_mag == 32'd0) begin
                // Magnitude plus sign flag reconstructs the original rs.
                res_lo = 32'hFFFF_FFFF;
                res_hi = neg_rem ? (~a_mag + 32'd1) : a_mag;
            end else begin
                res_lo = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
                res_hi = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept_iter) next_state = CALC;
            CALC: if (cnt == 5'(md_iter - 1)) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= md_mult;
            a_mag   <= '0;
            b_mag   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_iter) begin
                op_q    <= mdop_i;
                a_mag   <= mag(srca_i, sgn);
                b_mag   <= mag(srcb_i, sgn);
                neg_res <= sgn & (srca_i[31] ^ srcb_i[31]);
                neg_rem <= sgn & srca_i[31];
                acc     <= '0;
                cnt     <= '0;
            end
            if (accept_mv) begin
                if (mdop_i == md_mthi) hi <= srca_i;
                else                   lo <= srca_i;
            end
            if (state == CALC) begin
                acc <= is_div ? div_next : mul_next;
                cnt <= cnt + 5'd1;
            end
            if (state == FIX) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: multiply, divide, move-to, busy and reset cases.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  mdop_i;
    logic [31:0] srca_i;
    logic [31:0] srcb_i;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    mdu dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .mdop_i  (mdop_i),
        .srca_i  (srca_i),
        .srcb_i  (srcb_i),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op at a negedge; returns #1 after the sampling edge E0.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start_i = 1'b1;
        mdop_i  = op;
        srca_i  = a;
        srcb_i  = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        srca_i  = 32'hDEAD_BEEF;
        srcb_i  = 32'hCAFE_F00D;
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        int early;
        issue(op, a, b);
        chk({tag, " busy0"}, {31'd0, busy}, 32'd1);
        k     = 0;
        early = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
            if (!busy) early++;
        end
        chk({tag, " lat"}, k, 33);
        chk({tag, " idle_early"}, early, 0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int k;
        int pulses;
        int first;

        rst     = 1'b1;
        start_i = 1'b0;
        mdop_i  = 3'd0;
        srca_i  = '0;
        srcb_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);

        run("mult", 3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("multu", 3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
        run("mult_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001);
        run("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
        run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000);
        run("div_negb", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
        run("div_nega", 3'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        run("divu_z", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run("div_z", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        issue(3'd4, 32'h1234, 32'h0);
        chk("mthi hi", hi, 32'h1234);
        chk("mthi lo", lo, 32'hFFFF_FFFF);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("mthi done", {31'd0, done}, 32'd0);

        @(negedge clk);
        start_i = 1'b1;
        mdop_i  = 3'd5;
        srca_i  = 32'hA;
        @(posedge clk);
        #1;
        chk("mtlo1", lo, 32'hA);
        srca_i = 32'hB;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("mtlo2", lo, 32'hB);
        chk("mtlo hi", hi, 32'h1234);
        chk("mtlo busy", {31'd0, busy}, 32'd0);

        issue(3'd6, 32'h5555, 32'h7);
        chk("inval busy", {31'd0, busy}, 32'd0);
        chk("inval hi", hi, 32'h1234);
        chk("inval lo", lo, 32'hB);

        // Restart attempt at E10 of a multu must be ignored.
        issue(3'd1, 32'hFFFF_FFFF, 32'h2);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start_i = 1'b1;
        mdop_i  = 3'd2;
        srca_i  = 32'd100;
        srcb_i  = 32'd7;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        k      = 10;
        pulses = 0;
        first  = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        chk("busy_ign first", first, 33);
        chk("busy_ign pulses", pulses, 1);
        chk("busy_ign hi", hi, 32'h1);
        chk("busy_ign lo", lo, 32'hFFFF_FFFE);

        // Reset at E10 of a div aborts it with no result written.
        issue(3'd2, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort hi", hi, 32'h0);
        chk("abort lo", lo, 32'h0);
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk("abort quiet", pulses, 0);
        chk("abort hold hi", hi, 32'h0);

        run("divu_post", 3'd3, 32'd9, 32'd4, 32'd1, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
